// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and rotating-priority pick function
// for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SELW  = 3;
    localparam int DW    = 32;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Returns {found, index}; searches ptr, ptr+1, ... ptr+7 (mod 8).
    // Walking backwards lets the lowest rotated offset win the last write.
    function automatic logic [SELW:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [SELW-1:0]  ptr);
        logic [SELW:0]   res;
        logic [SELW-1:0] cand;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SELW'(i);
            if (req[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

endpackage

// File: rtl/MUX8T1_32.sv
// 32-bit 8:1 multiplexer, shared datapath for the arbiter.
module MUX8T1_32 (
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic [31:0] I4,
    input  logic [31:0] I5,
    input  logic [31:0] I6,
    input  logic [31:0] I7,
    input  logic [2:0]  s,
    output logic [31:0] o
);

    always_comb begin
        case (s)
            3'd0:    o = I0;
            3'd1:    o = I1;
            3'd2:    o = I2;
            3'd3:    o = I3;
            3'd4:    o = I4;
            3'd5:    o = I5;
            3'd6:    o = I6;
            default: o = I7;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter_prio_enc8.sv
// Combinational rotating priority encoder: first set request at or after ptr.
module rr_prio_enc8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SELW-1:0]  ptr,
    output logic             found,
    output logic [SELW-1:0]  idx
);

    logic [SELW:0] pick;

    always_comb begin
        pick  = rr_pick(req, ptr);
        found = pick[SELW];
        idx   = pick[SELW-1:0];
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 requesters (valid/ready out).
// Define ARB_LOCK_EN to add the lock[] port for same-index bursts.
//
// state    | meaning
// ST_IDLE  | no grant outstanding; arbitrate, ack of previous accept visible
// ST_GRANT | sel holds winner, o_valid=1, waiting for o_ready or abort
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [DW-1:0]    I0,
    input  logic [DW-1:0]    I1,
    input  logic [DW-1:0]    I2,
    input  logic [DW-1:0]    I3,
    input  logic [DW-1:0]    I4,
    input  logic [DW-1:0]    I5,
    input  logic [DW-1:0]    I6,
    input  logic [DW-1:0]    I7,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0] lock,
`endif
    input  logic             o_ready,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    output logic [SELW-1:0]  sel,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    logic [0:0]       state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             pick_found;
    logic [SELW-1:0]  pick_idx;
    logic             hold_lock;

    rr_prio_enc8 u_prio (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_LOCK_EN
    assign hold_lock = lock[sel_q];
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            default: begin
                // Abort wins over o_ready: a withdrawn word is never acked.
                if (!req[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (o_ready) begin
                    ack_d[sel_q] = 1'b1;
                    if (!hold_lock) begin
                        state_d = ST_IDLE;
                        ptr_d   = sel_q + SELW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
        end
    end

    MUX8T1_32 u_mux (
        .I0 (I0),
        .I1 (I1),
        .I2 (I2),
        .I3 (I3),
        .I4 (I4),
        .I5 (I5),
        .I6 (I6),
        .I7 (I7),
        .s  (sel_q),
        .o  (o_data)
    );

    assign o_valid = (state_q == ST_GRANT);
    assign busy    = (state_q == ST_GRANT);
    assign sel     = sel_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter; build with ARB_LOCK_EN
// to also exercise the lock burst.
module tb_mux8_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [31:0] I0, I1, I2, I3, I4, I5, I6, I7;
    logic [7:0]  lock;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic [2:0]  sel;
    logic [7:0]  ack;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux8_rr_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .I4      (I4),
        .I5      (I5),
        .I6      (I6),
        .I7      (I7),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .sel     (sel),
        .ack     (ack),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({o_valid, sel, ack, busy} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%0b sel=%0d ack=%h busy=%0b, want all 0",
                         o_valid, sel, ack, busy);
            end
            n_checks++;
            if (o_data !== I0) begin
                n_fail++;
                $display("FAIL reset_data: got %h, want %h", o_data, I0);
            end
        end
        req = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [2:0]  e;
        logic [31:0] ed;
        logic [7:0]  ea;
        o_ready = 1'b1;
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            e  = 3'(g % 8);
            ed = 32'(e) + 32'd1;
            ea = 8'd1 << e;
            tick();
            n_checks++;
            if (o_valid !== 1'b1 || busy !== 1'b1 || sel !== e || o_data !== ed || ack !== 8'h00) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got valid=%0b busy=%0b sel=%0d data=%h ack=%h, want 1 1 %0d %h 00",
                         g, o_valid, busy, sel, o_data, ack, e, ed);
            end
            tick();
            n_checks++;
            if (o_valid !== 1'b0 || ack !== ea) begin
                n_fail++;
                $display("FAIL rr_ack%0d: got valid=%0b ack=%h, want 0 %h", g, o_valid, ack, ea);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        I4 = 32'hDEADBEEF;
        o_ready = 1'b0;
        req = 8'h10;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (o_valid !== 1'b1 || sel !== 3'd4 || o_data !== 32'hDEADBEEF || ack !== 8'h00) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%0b sel=%0d data=%h ack=%h, want 1 4 deadbeef 00",
                         c, o_valid, sel, o_data, ack);
            end
            if (c == 6) o_ready = 1'b1;
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || ack !== 8'h10) begin
            n_fail++;
            $display("FAIL bp_ack: got valid=%0b ack=%h, want 0 10", o_valid, ack);
        end
        req = 8'h00;
        tick();
        n_checks++;
        if (ack !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_single_ack: got ack=%h, want 00", ack);
        end
    endtask

    task automatic test_wrap();
        o_ready = 1'b1;
        req = 8'h40;
        tick();
        n_checks++;
        if (sel !== 3'd6 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_g6: got sel=%0d valid=%0b, want 6 1", sel, o_valid);
        end
        tick();
        req = 8'h81;
        tick();
        n_checks++;
        if (sel !== 3'd7 || o_data !== 32'd8) begin
            n_fail++;
            $display("FAIL wrap_first: got sel=%0d data=%h, want 7 00000008", sel, o_data);
        end
        tick();
        n_checks++;
        if (ack !== 8'h80) begin
            n_fail++;
            $display("FAIL wrap_ack7: got ack=%h, want 80", ack);
        end
        tick();
        n_checks++;
        if (sel !== 3'd0 || o_valid !== 1'b1 || o_data !== 32'd1) begin
            n_fail++;
            $display("FAIL wrap_second: got sel=%0d valid=%0b data=%h, want 0 1 00000001", sel, o_valid, o_data);
        end
        tick();
        req = 8'h00;
        n_checks++;
        if (ack !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_ack0: got ack=%h, want 01", ack);
        end
        tick();
    endtask

    // ptr is 1 here; req 0x05 picks 2 from ptr 1 but 0 from ptr 3.
    task automatic test_abort();
        o_ready = 1'b0;
        req = 8'h04;
        tick();
        n_checks++;
        if (sel !== 3'd2 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_grant: got sel=%0d valid=%0b, want 2 1", sel, o_valid);
        end
        req = 8'h00;
        o_ready = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || ack !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_drop: got valid=%0b busy=%0b ack=%h, want 0 0 00", o_valid, busy, ack);
        end
        req = 8'h05;
        tick();
        n_checks++;
        if (sel !== 3'd2 || o_valid !== 1'b1 || ack !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_ptr_kept: got sel=%0d valid=%0b ack=%h, want 2 1 00", sel, o_valid, ack);
        end
        tick();
        req = 8'h00;
        n_checks++;
        if (ack !== 8'h04) begin
            n_fail++;
            $display("FAIL abort_then_ack: got ack=%h, want 04", ack);
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        o_ready = 1'b0;
        req = 8'h02;
        tick();
        n_checks++;
        if (sel !== 3'd1 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant: got sel=%0d valid=%0b, want 1 1", sel, o_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || sel !== 3'd0 || ack !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_clear: got valid=%0b busy=%0b sel=%0d ack=%h, want 0 0 0 00",
                     o_valid, busy, sel, ack);
        end
        o_ready = 1'b1;
        tick();
        req = 8'h00;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (ack !== 8'h00 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_ack: got ack=%h valid=%0b, want 00 0", ack, o_valid);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        o_ready = 1'b1;
        lock = 8'h01;
        req = 8'h09;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (sel !== 3'd0 || o_valid !== 1'b1 || ack !== ((c == 1) ? 8'h00 : 8'h01)) begin
                n_fail++;
                $display("FAIL lock_burst%0d: got sel=%0d valid=%0b ack=%h", c, sel, o_valid, ack);
            end
        end
        lock = 8'h00;
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || ack !== 8'h01) begin
            n_fail++;
            $display("FAIL lock_end: got valid=%0b ack=%h, want 0 01", o_valid, ack);
        end
        tick();
        n_checks++;
        if (sel !== 3'd3 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_next: got sel=%0d valid=%0b, want 3 1", sel, o_valid);
        end
        req = 8'h00;
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req = 8'h00;
        lock = 8'h00;
        o_ready = 1'b0;
        I0 = 32'd1; I1 = 32'd2; I2 = 32'd3; I3 = 32'd4;
        I4 = 32'd5; I5 = 32'd6; I6 = 32'd7; I7 = 32'd8;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_abort();
        test_reset_mid_grant();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit 8:1 multiplexer (MUX8T1_32) among 8 requesters.
- Each requester presents a request line and a 32-bit word. The block picks one requester, drives the mux select and presents the word downstream under a valid/ready handshake.
- It then acknowledges the winner and advances the priority pointer.
- Sits between peripheral/register sources and a single shared bus consumer (display or bus write port).

Parameters:
- N_REQ, 8, number of requesters; fixed to 8 to match the 3-bit mux select.
- DW, 32, data width of each source and of the output.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  per-requester request; bit i = requester i
- I0..I7  input  32 each  requester data words; Ii must be held stable while req[i]=1
- o_ready  input  1  downstream consumer accepts o_data this cycle
- o_valid  output  1  o_data holds a granted word
- o_data  output  32  word selected by sel, taken from the MUX8T1_32 output
- sel  output  3  registered mux select / index of the current grant
- ack  output  8  one-hot, single-cycle pulse to the requester whose word was accepted
- busy  output  1  a grant is outstanding (state GRANT)

Behaviour:
- Reset values (async, while rst_n=0):
  - o_valid=0, sel=0, ack=0, busy=0
  - priority pointer ptr=0, state=IDLE
  - o_data follows I0 combinationally.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit searching ptr, ptr+1, …, ptr+7 (mod 8).
  - Register the winner into sel, set o_valid=1 and busy=1, go to GRANT.
  - Latency: req sampled on edge k gives o_valid high after edge k.
- GRANT, o_valid=1:
  - If o_ready=1 and req[sel]=1: accept. Next cycle ack[sel]=1 for exactly one cycle, o_valid=0, ptr=sel+1 (mod 8, 7 wraps to 0), return to IDLE.
  - If o_ready=0 and req[sel]=1: hold. sel and o_data stay unchanged.
  - If req[sel] drops before accept: abort. Next cycle o_valid=0, no ack, ptr unchanged, return to IDLE.
  - Abort has priority over o_ready in the same cycle.
- Throughput: at most one word per 2 cycles (GRANT, then IDLE re-arbitration). ack and the next arbitration happen in the same IDLE cycle.
- A requester whose ack is high must deassert req that cycle if it has no further word. If req stays high it competes again at lowest priority, because ptr has passed it.
- New requests arriving during GRANT are ignored until IDLE.
- o_data is combinational from the mux using the registered sel, so it is glitch-free while valid.
- rst_n asserted mid-GRANT: outputs clear immediately, no ack is issued, and the word is discarded.
- Fairness: any continuously asserted request is granted within 8 grants.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds input lock[7:0].
  - On accept, if lock[sel]=1 and req[sel]=1, the arbiter goes directly to the next GRANT of the same index without passing IDLE.
  - o_valid stays 1, ack[sel] pulses, ptr is not advanced. This is a burst of one word per cycle.
  - The burst ends on the first accept with lock[sel]=0, or on abort.
- When undefined: no lock port, and every accept returns to IDLE as above.

Decomposition:
- Shared package mux8_arb_pkg holds:
  - localparams N_REQ=8, SELW=3, DW=32
  - state encoding ST_IDLE=1'b0, ST_GRANT=1'b1
  - function rr_pick(req, ptr) returning {found, index}
- One natural sub-module: rr_prio_enc8 (rotating priority encoder, combinational).
- MUX8T1_32 is instantiated unchanged as the datapath.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 100 ns with req=8'hFF.
  - Response: o_valid=0, sel=0, ack=0, busy=0 throughout.
- Round-robin:
  - Stimulus: I0..I7 = 1..8; req=8'hFF held; o_ready=1.
  - Response: accepted o_data sequence 1,2,3,…,8,1; ack walks 01,02,…,80,01; a new word every 2 cycles.
- Backpressure:
  - Stimulus: req=8'h10, I4=32'hDEADBEEF, o_ready=0 for 5 cycles, then 1.
  - Response: o_valid stays high with o_data=DEADBEEF and sel=4 for 6 cycles; exactly one ack=8'h10.
- Wrap/priority:
  - Stimulus: ptr=7 after granting 6; then req=8'h81.
  - Response: requester 7 granted first, then 0.
- Abort:
  - Stimulus: req[2] dropped while in GRANT with o_ready=0.
  - Response: o_valid falls next cycle; no ack; the next grant search starts from the old ptr.
- Lock (ARB_LOCK_EN):
  - Stimulus: req=8'h09, lock=8'h01, o_ready=1 for 4 cycles.
  - Response: 4 consecutive cycles of sel=0 with ack pulses; lock drops, then sel=3.
